cancid_pkt_dispatch: RTL and testbench

Front end driving a bank of NUM_CAT per-category regex matchers, all sharing the same stream_id / load_state / char / eop bus. Each packet's flow key maps to one of 64 stream slots, allocating a slot on a miss. The block pulses load_state so each matcher restores or clears its saved state, then streams the payload bytes and issues eop. It samples the matchers' fired vector and emits one result per packet.

---
 rtl/cancid_dispatch_pkg.sv | 27 ++
 rtl/cancid_stream_table.sv | 99 +++++++++
 rtl/cancid_pkt_dispatch.sv | 197 +++++++++++++++++++
 tb/tb_cancid_pkt_dispatch.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cancid_dispatch_pkg.sv
// Shared types for the packet dispatch front end: FSM states, stream-table
// geometry and the per-packet result record.
package cancid_dispatch_pkg;

    localparam int NUM_STREAMS = 64;
    localparam int SID_W       = 6;
    // Widest category vector a result record can carry; instances use the low NUM_CAT bits.
    localparam int MAX_CAT     = 32;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        LOAD,
        GAP,
        STREAM,
        DRAIN,
        EOP,
        RESULT
    } state_e;

    typedef struct packed {
        logic [SID_W-1:0]   sid;
        logic               is_new;
        logic [MAX_CAT-1:0] match;
    } res_t;

endpackage

// File: rtl/cancid_stream_table.sv
// Flow-key CAM with valid bits, free-slot/round-robin allocation and the
// per-stream category enable memory (cfg port has priority over allocation).
module cancid_stream_table
    import cancid_dispatch_pkg::*;
#(
    parameter int                 NUM_CAT    = 8,
    parameter int                 KEY_W      = 32,
    parameter logic [NUM_CAT-1:0] DEFAULT_EN = '1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               lkp_en,
    input  logic [KEY_W-1:0]   lkp_key,
    output logic [SID_W-1:0]   lkp_sid,
    output logic               lkp_new,
    input  logic               cfg_we,
    input  logic [SID_W-1:0]   cfg_addr,
    input  logic [NUM_CAT-1:0] cfg_en,
    input  logic [SID_W-1:0]   rd_sid,
    output logic [NUM_CAT-1:0] rd_en
);

    logic [NUM_STREAMS-1:0]              vld_q, vld_d;
    logic [NUM_STREAMS-1:0][KEY_W-1:0]   key_q;
    logic [NUM_STREAMS-1:0][NUM_CAT-1:0] en_q;
    logic [SID_W-1:0]                    rp_q, rp_d;

    logic [NUM_STREAMS-1:0] hit_vec;
    logic                   hit, has_free, alloc;
    logic [SID_W-1:0]       hit_idx, free_idx;

    always_comb begin
        for (int i = 0; i < NUM_STREAMS; i++) begin
            hit_vec[i] = vld_q[i] && (key_q[i] == lkp_key);
        end
    end

    // Descending scan so the lowest matching / lowest free index wins.
    always_comb begin
        hit      = 1'b0;
        hit_idx  = '0;
        has_free = 1'b0;
        free_idx = '0;
        for (int i = NUM_STREAMS - 1; i >= 0; i--) begin
            if (hit_vec[i]) begin
                hit     = 1'b1;
                hit_idx = SID_W'(i);
            end
            if (!vld_q[i]) begin
                has_free = 1'b1;
                free_idx = SID_W'(i);
            end
        end
    end

    always_comb begin
        vld_d   = vld_q;
        rp_d    = rp_q;
        lkp_new = !hit;
        alloc   = lkp_en && !hit;
        if (hit) begin
            lkp_sid = hit_idx;
        end else if (has_free) begin
            lkp_sid = free_idx;
        end else begin
            lkp_sid = rp_q;
        end
        if (alloc) begin
            vld_d[lkp_sid] = 1'b1;
            if (!has_free) begin
                rp_d = rp_q + SID_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            rp_q  <= '0;
        end else begin
            vld_q <= vld_d;
            rp_q  <= rp_d;
        end
    end

    // Key and enable storage carry no reset; validity alone qualifies them.
    always_ff @(posedge clk) begin
        if (alloc) begin
            key_q[lkp_sid] <= lkp_key;
            en_q[lkp_sid]  <= DEFAULT_EN;
        end
        if (cfg_we) begin
            en_q[cfg_addr] <= cfg_en;
        end
    end

    assign rd_en = en_q[rd_sid];

endmodule

// File: rtl/cancid_pkt_dispatch.sv
// Packet front end for a bank of category matchers: maps flow keys to stream
// slots, sequences load/stream/eop on the shared bus and reports one result per packet.
module cancid_pkt_dispatch
    import cancid_dispatch_pkg::*;
#(
    parameter int                 NUM_CAT    = 8,
    parameter int                 KEY_W      = 32,
    parameter logic [NUM_CAT-1:0] DEFAULT_EN = '1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [7:0]         in_data,
    input  logic               in_sop,
    input  logic               in_eop,
    input  logic [KEY_W-1:0]   in_key,
    input  logic               cfg_we,
    input  logic [SID_W-1:0]   cfg_addr,
    input  logic [NUM_CAT-1:0] cfg_en,
    output logic [7:0]         char_in,
    output logic               char_in_vld,
    output logic               load_state,
    output logic [SID_W-1:0]   stream_id,
    output logic               new_stream_id,
    output logic [NUM_CAT-1:0] enable,
    output logic               eop,
    input  logic [NUM_CAT-1:0] fired,
    output logic               res_vld,
    output logic [SID_W-1:0]   res_sid,
    output logic               res_new,
    output logic [NUM_CAT-1:0] res_match,
    output logic [15:0]        pkt_cnt,
    output logic [15:0]        drop_cnt
);

    state_e             state_q, state_d;
    logic [KEY_W-1:0]   key_q, key_d;
    logic [SID_W-1:0]   sid_q, sid_d;
    logic               new_q, new_d;
    logic               first_q, first_d;
    logic               tail_q, tail_d;
    logic [7:0]         char_q, char_d;
    logic               char_vld_q, char_vld_d;
    res_t               res_q, res_d;
    logic [15:0]        pkt_q, pkt_d;
    logic [15:0]        drop_q, drop_d;

    logic               lkp_en, tbl_new;
    logic [SID_W-1:0]   tbl_sid;
    logic [NUM_CAT-1:0] tbl_en;
    logic               active;
    logic               res_unused;

    cancid_stream_table #(
        .NUM_CAT    (NUM_CAT),
        .KEY_W      (KEY_W),
        .DEFAULT_EN (DEFAULT_EN)
    ) u_table (
        .clk      (clk),
        .rst      (rst),
        .lkp_en   (lkp_en),
        .lkp_key  (key_q),
        .lkp_sid  (tbl_sid),
        .lkp_new  (tbl_new),
        .cfg_we   (cfg_we),
        .cfg_addr (cfg_addr),
        .cfg_en   (cfg_en),
        .rd_sid   (sid_q),
        .rd_en    (tbl_en)
    );

    always_comb begin
        state_d    = state_q;
        key_d      = key_q;
        sid_d      = sid_q;
        new_d      = new_q;
        first_d    = first_q;
        tail_d     = tail_q;
        char_d     = char_q;
        char_vld_d = 1'b0;
        res_d      = res_q;
        pkt_d      = pkt_q;
        drop_d     = drop_q;
        in_ready   = 1'b0;
        lkp_en     = 1'b0;
        load_state = 1'b0;
        eop        = 1'b0;
        res_vld    = 1'b0;
        case (state_q)
            IDLE: begin
                // The sop beat is stalled here and accepted later as the first byte.
                if (in_valid && in_sop) begin
                    key_d   = in_key;
                    state_d = LOOKUP;
                end else if (in_valid) begin
                    in_ready = 1'b1;
                    drop_d   = drop_q + 16'd1;
                end
            end
            LOOKUP: begin
                lkp_en  = 1'b1;
                sid_d   = tbl_sid;
                new_d   = tbl_new;
                state_d = LOAD;
            end
            LOAD: begin
                load_state = 1'b1;
                first_d    = 1'b1;
                tail_d     = 1'b0;
                state_d    = GAP;
            end
            GAP: begin
                state_d = STREAM;
            end
            STREAM: begin
                // After the last byte, stay one cycle so it clears the byte register.
                if (tail_q) begin
                    state_d = DRAIN;
                end else begin
                    in_ready = 1'b1;
                    if (in_valid) begin
                        char_d     = in_data;
                        char_vld_d = 1'b1;
                        first_d    = 1'b0;
                        if (in_sop && !first_q) begin
                            drop_d = drop_q + 16'd1;
                        end
                        if (in_eop) begin
                            tail_d = 1'b1;
                        end
                    end
                end
            end
            DRAIN: begin
                state_d = EOP;
            end
            EOP: begin
                eop          = 1'b1;
                res_d.sid    = sid_q;
                res_d.is_new = new_q;
                res_d.match  = MAX_CAT'(fired & tbl_en);
                state_d      = RESULT;
            end
            RESULT: begin
                res_vld = 1'b1;
                pkt_d   = pkt_q + 16'd1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            key_q      <= '0;
            sid_q      <= '0;
            new_q      <= 1'b0;
            first_q    <= 1'b0;
            tail_q     <= 1'b0;
            char_q     <= '0;
            char_vld_q <= 1'b0;
            res_q      <= '0;
            pkt_q      <= '0;
            drop_q     <= '0;
        end else begin
            state_q    <= state_d;
            key_q      <= key_d;
            sid_q      <= sid_d;
            new_q      <= new_d;
            first_q    <= first_d;
            tail_q     <= tail_d;
            char_q     <= char_d;
            char_vld_q <= char_vld_d;
            res_q      <= res_d;
            pkt_q      <= pkt_d;
            drop_q     <= drop_d;
        end
    end

    assign active = (state_q == LOAD) || (state_q == GAP) || (state_q == STREAM)
                 || (state_q == DRAIN) || (state_q == EOP);

    assign char_in       = char_q;
    assign char_in_vld   = char_vld_q;
    assign stream_id     = active ? sid_q  : '0;
    assign new_stream_id = active ? new_q  : 1'b0;
    assign enable        = active ? tbl_en : '0;
    assign res_sid       = res_vld ? res_q.sid                 : '0;
    assign res_new       = res_vld ? res_q.is_new              : 1'b0;
    assign res_match     = res_vld ? res_q.match[NUM_CAT-1:0]  : '0;
    assign pkt_cnt       = pkt_q;
    assign drop_cnt      = drop_q;
    assign res_unused    = ^res_q;

endmodule

// File: tb/tb_cancid_pkt_dispatch.sv
// Randomized bench for cancid_pkt_dispatch against a slot-allocation and
// packet-timing reference model.
module tb_cancid_pkt_dispatch;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0, in_ready, in_sop = 1'b0, in_eop = 1'b0;
    logic [7:0]  in_data = '0;
    logic [31:0] in_key = '0;
    logic        cfg_we = 1'b0;
    logic [5:0]  cfg_addr = '0;
    logic [7:0]  cfg_en = '0;
    logic [7:0]  char_in;
    logic        char_in_vld, load_state, new_stream_id, eop, res_vld, res_new;
    logic [5:0]  stream_id, res_sid;
    logic [7:0]  enable, fired, res_match, fired_cur = '0;
    logic [15:0] pkt_cnt, drop_cnt;

    int n_chk = 0;
    int n_err = 0;

    // reference model state
    logic [31:0] m_key [64];
    bit          m_vld [64];
    logic [7:0]  m_en  [64];
    int          m_rp, m_pkts, m_drop;

    always #5 clk = ~clk;

    // Matchers' flags are only meaningful on the eop cycle; elsewhere show the complement.
    assign fired = eop ? fired_cur : ~fired_cur;

    cancid_pkt_dispatch dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_sop(in_sop), .in_eop(in_eop), .in_key(in_key),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_en(cfg_en),
        .char_in(char_in), .char_in_vld(char_in_vld), .load_state(load_state),
        .stream_id(stream_id), .new_stream_id(new_stream_id), .enable(enable),
        .eop(eop), .fired(fired), .res_vld(res_vld), .res_sid(res_sid),
        .res_new(res_new), .res_match(res_match), .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < 64; i++) m_vld[i] = 0;
        m_rp = 0; m_pkts = 0; m_drop = 0;
    endtask

    task automatic m_lookup(input logic [31:0] k, output int sid, output bit nw);
        sid = -1;
        for (int i = 0; i < 64; i++) if (m_vld[i] && m_key[i] == k) sid = i;
        nw = (sid < 0);
        if (nw) begin
            for (int i = 63; i >= 0; i--) if (!m_vld[i]) sid = i;
            if (sid < 0) begin
                sid  = m_rp;
                m_rp = (m_rp + 1) % 64;
            end
            m_vld[sid] = 1; m_key[sid] = k; m_en[sid] = 8'hFF;
        end
    endtask

    function automatic logic [127:0] all_outs();
        return 128'({in_ready, char_in, char_in_vld, load_state, stream_id, new_stream_id,
                     enable, eop, res_vld, res_sid, res_new, res_match, pkt_cnt, drop_cnt});
    endfunction

    task automatic do_reset();
        in_valid = 0; in_sop = 0; in_eop = 0; cfg_we = 0;
        rst = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_outs", all_outs(), 128'(0));
        @(posedge clk); #1;
        rst = 0;
        m_reset();
    endtask

    task automatic cfg_write(input int addr, input logic [7:0] en);
        cfg_we = 1; cfg_addr = 6'(addr); cfg_en = en;
        @(posedge clk); #1;
        cfg_we = 0;
        m_en[addr] = en;
    endtask

    task automatic idle_drop();
        in_valid = 1; in_sop = 0; in_eop = 0; in_data = 8'hEE;
        @(negedge clk);
        chk("idle_drop_ready", 128'(in_ready), 128'(1));
        @(posedge clk); #1;
        in_valid = 0;
        m_drop++;
    endtask

    // Sends one packet and checks the whole bus sequence cycle by cycle.
    // cw: a cfg write hits the packet's own slot during the lookup cycle.
    task automatic send_pkt(input logic [31:0] key, input int len, input bit gaps,
                            input bit inj, input logic [7:0] fv, input bit cw,
                            input logic [7:0] cv);
        int sid, tx, rx, cyc, last_acc;
        bit nw, done, acc;
        logic [7:0] exp_en;
        logic [7:0] data [$];
        m_lookup(key, sid, nw);
        if (cw) m_en[sid] = cv;
        exp_en = m_en[sid];
        if (inj && len > 1) m_drop++;
        for (int i = 0; i < len; i++) data.push_back(8'($urandom));
        fired_cur = fv;
        tx = 0; rx = 0; cyc = 0; last_acc = -100; done = 0;
        in_valid = 1; in_sop = 1; in_eop = (len == 1); in_data = data[0]; in_key = key;
        while (!done && cyc < 200) begin
            @(negedge clk);
            acc = in_valid && in_ready;
            if (cyc == 0) chk("sop_stall", 128'(in_ready), 128'(0));
            if (load_state) begin
                chk("load_cyc", 128'(cyc), 128'(2));
                chk("load_sid", 128'(stream_id), 128'(sid));
                chk("load_new", 128'(new_stream_id), 128'(nw));
                chk("load_en", 128'(enable), 128'(exp_en));
            end
            if (acc && tx == 0) chk("first_acc_cyc", 128'(cyc), 128'(4));
            if (char_in_vld) begin
                if (rx < len) chk("char", 128'(char_in), 128'(data[rx]));
                else chk("extra_char", 128'(1), 128'(0));
                rx++;
            end
            if (eop) begin
                chk("eop_cyc", 128'(cyc), 128'(last_acc + 3));
                chk("eop_sid", 128'(stream_id), 128'(sid));
                chk("eop_en", 128'(enable), 128'(exp_en));
            end
            if (res_vld) begin
                chk("res_cyc", 128'(cyc), 128'(last_acc + 4));
                chk("res_sid", 128'(res_sid), 128'(sid));
                chk("res_new", 128'(res_new), 128'(nw));
                chk("res_match", 128'(res_match), 128'(fv & exp_en));
                m_pkts++;
                done = 1;
            end
            @(posedge clk); #1;
            if (acc) begin
                if (tx == len - 1) last_acc = cyc;
                tx++;
            end
            cyc++;
            if (cw && cyc == 1) begin
                cfg_we = 1; cfg_addr = 6'(sid); cfg_en = cv;
            end else begin
                cfg_we = 0;
            end
            if (tx < len) begin
                in_valid = (tx == 0 || !gaps) ? 1'b1 : ($urandom_range(0, 2) != 0);
                in_sop   = (tx == 0) || (inj && tx == 1);
                in_eop   = (tx == len - 1);
                in_data  = data[tx];
            end else begin
                in_valid = 0; in_sop = 0; in_eop = 0;
            end
        end
        if (!done) chk("pkt_timeout", 128'(0), 128'(1));
        chk("byte_count", 128'(rx), 128'(len));
    endtask

    task automatic abort_pkt(input logic [31:0] key);
        int sid, cyc;
        bit nw, acc;
        m_lookup(key, sid, nw);
        in_valid = 1; in_sop = 1; in_eop = 0; in_data = 8'h5A; in_key = key;
        acc = 0; cyc = 0;
        while (!acc && cyc < 20) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
            cyc++;
            if (acc) in_sop = 0;
        end
        if (!acc) chk("abort_accept", 128'(0), 128'(1));
        rst = 1;
        in_valid = 0;
        @(negedge clk);
        chk("abort_streaming", 128'(char_in_vld), 128'(1));
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        chk("abort_outs_zero", all_outs(), 128'(0));
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("abort_no_res", 128'({eop, res_vld}), 128'(0));
        end
        @(posedge clk); #1;
        m_reset();
    endtask

    initial begin
        m_reset();
        do_reset();

        // directed: first packet, hit, cfg-disabled slot
        send_pkt(32'hA, 3, 0, 0, 8'h00, 0, 8'h00);
        send_pkt(32'hA, 2, 0, 0, 8'h04, 0, 8'h00);
        cfg_write(0, 8'h00);
        send_pkt(32'hA, 1, 0, 0, 8'hFF, 0, 8'h00);

        // drops in IDLE and mid-packet sop, gapped stream, cfg colliding with allocation
        idle_drop();
        send_pkt(32'hB, 6, 1, 0, 8'h81, 0, 8'h00);
        send_pkt(32'hB, 4, 1, 1, 8'h0F, 0, 8'h00);
        send_pkt(32'hC, 2, 0, 0, 8'hFF, 1, 8'h3C);
        chk("pkt_cnt_dir", 128'(pkt_cnt), 128'(m_pkts));
        chk("drop_cnt_dir", 128'(drop_cnt), 128'(m_drop));

        // reset mid-packet, then the same key must allocate fresh
        abort_pkt(32'hD);
        send_pkt(32'hD, 2, 0, 0, 8'h11, 0, 8'h00);

        // fill the table, then two evictions
        do_reset();
        for (int i = 0; i < 66; i++) send_pkt(32'h1000 + 32'(i), 1, 0, 0, 8'h55, 0, 8'h00);

        // randomized traffic over more keys than slots
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 7) == 0) cfg_write($urandom_range(0, 63), 8'($urandom));
            if ($urandom_range(0, 7) == 0) idle_drop();
            send_pkt(32'h2000 + 32'($urandom_range(0, 79)), $urandom_range(1, 6),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
                     8'($urandom), 1'($urandom_range(0, 5) == 0), 8'($urandom));
        end
        chk("pkt_cnt_end", 128'(pkt_cnt), 128'(m_pkts));
        chk("drop_cnt_end", 128'(drop_cnt), 128'(m_drop));

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
